// File: rtl/csa_accum_64.sv
// Carry-save accumulator: folds a group of 64-bit operands into a redundant (S, C) pair
// for a downstream adder. Optional subtract beats are enabled with `define CSA_ACC_SUB_EN.
module csa_accum_64 #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [CNT_W-1:0]  out_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   s_q, s_d;
  logic [DATA_W-1:0]   c_q, c_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                sub_beat;
  logic [DATA_W-1:0]   opnd;
  logic [DATA_W-1:0]   csa_sum;
  logic [DATA_W-2:0]   csa_maj;
  logic [DATA_W-1:0]   csa_carry;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

`ifdef CSA_ACC_SUB_EN
  assign sub_beat = in_sub;
`else
  logic unused_in_sub;
  assign unused_in_sub = in_sub;
  assign sub_beat      = 1'b0;
`endif

  // Subtraction is two's complement: invert the operand and inject the +1 into the free C[0] slot.
  assign opnd      = sub_beat ? ~in_data : in_data;
  assign csa_sum   = s_q ^ c_q ^ opnd;
  assign csa_maj   = (s_q[DATA_W-2:0] & c_q[DATA_W-2:0])
                   | (s_q[DATA_W-2:0] & opnd[DATA_W-2:0])
                   | (c_q[DATA_W-2:0] & opnd[DATA_W-2:0]);
  assign csa_carry = {csa_maj, sub_beat};

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, ACC: begin
        if (in_valid) begin
          s_d     = csa_sum;
          c_d     = csa_carry;
          cnt_d   = sat_inc(cnt_q);
          state_d = in_last ? HOLD : ACC;
        end
      end
      HOLD: begin
        if (out_ready) begin
          s_d     = '0;
          c_d     = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
    end
  end

  // No bypass from the output handshake: a new group waits one cycle after HOLD releases.
  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign out_a     = s_q;
  assign out_b     = c_q;
  assign out_count = cnt_q;

endmodule

// File: tb/tb_csa_accum_64.sv
// Scoreboard bench for csa_accum_64: directed groups push expected (sum, count) pairs,
// a monitor pops and checks them on every output handshake.
module tb_csa_accum_64;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_last;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_a;
  logic [63:0] out_b;
  logic [7:0]  out_count;

  typedef struct {
    logic [63:0] sum;
    logic [7:0]  cnt;
    bit          chk_ab;
    logic [63:0] a;
    logic [63:0] b;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  csa_accum_64 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [63:0] sum, input logic [7:0] cnt);
    exp_t e;
    e.sum = sum; e.cnt = cnt; e.chk_ab = 1'b0; e.a = '0; e.b = '0;
    sb.push_back(e);
  endtask

  // Monitor: every HOLD cycle with out_ready high is exactly one handshake.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output: got out_a=0x%0h out_b=0x%0h, expected no output", out_a, out_b);
      end else begin
        exp_t e;
        logic [63:0] s;
        e = sb.pop_front();
        s = out_a + out_b;
        chk("group_sum", s, e.sum);
        chk("group_count", {56'd0, out_count}, {56'd0, e.cnt});
        if (e.chk_ab) begin
          chk("single_a", out_a, e.a);
          chk("single_b", out_b, e.b);
        end
`ifndef CSA_ACC_SUB_EN
        chk("carry_lsb_zero", {63'd0, out_b[0]}, 64'd0);
`endif
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the beat was accepted.
  task automatic send_beat(input logic [63:0] d, input logic last, input logic sub);
    logic rdy;
    int   n;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_sub   = sub;
    n = 0;
    do begin
      rdy = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 50);
    if (!rdy) begin
      n_chk++;
      n_fail++;
      $display("FAIL beat_accept_timeout: got in_ready=0 for %0d cycles, expected acceptance", n);
    end
  endtask

  task automatic idle(input int cycles);
    in_valid = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [63:0] a0, b0;
    logic [7:0]  c0;
    int          n;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    in_sub    = 1'b0;
    out_ready = 1'b1;
    #1 rst = 1'b0;
    #2;
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_out_a", out_a, 64'd0);
    chk("reset_out_b", out_b, 64'd0);
    chk("reset_out_count", {56'd0, out_count}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    idle(1);

    // 5 + 7 + 9, output the cycle after the last beat.
    push(64'd21, 8'd3);
    send_beat(64'd5, 1'b0, 1'b0);
    send_beat(64'd7, 1'b0, 1'b0);
    chk("latency_not_early", {63'd0, out_valid}, 64'd0);
    send_beat(64'd9, 1'b1, 1'b0);
    chk("latency_one_cycle", {63'd0, out_valid}, 64'd1);
    idle(2);

    // Wrap-around: all-ones + 2 = 1 mod 2^64.
    push(64'd1, 8'd2);
    send_beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    send_beat(64'd2, 1'b1, 1'b0);
    idle(2);

    // Single-beat group presents S=D, C=0.
    begin
      exp_t e;
      e.sum = 64'hDEAD_BEEF_0123_4567; e.cnt = 8'd1; e.chk_ab = 1'b1;
      e.a = 64'hDEAD_BEEF_0123_4567; e.b = 64'd0;
      sb.push_back(e);
    end
    send_beat(64'hDEAD_BEEF_0123_4567, 1'b1, 1'b0);
    idle(2);

    // Idle gaps with garbage on the bus must not disturb the group.
    push(64'd7, 8'd2);
    send_beat(64'd3, 1'b0, 1'b0);
    in_data = 64'hFFFF; in_last = 1'b1;
    idle(3);
    send_beat(64'd4, 1'b1, 1'b0);
    idle(2);

    // Back-pressure in HOLD with a beat waiting upstream.
    push(64'd30, 8'd2);
    push(64'd77, 8'd1);
    out_ready = 1'b0;
    send_beat(64'd10, 1'b0, 1'b0);
    send_beat(64'd20, 1'b1, 1'b0);
    in_valid = 1'b1; in_data = 64'd77; in_last = 1'b1; in_sub = 1'b0;
    a0 = out_a; b0 = out_b; c0 = out_count;
    for (int i = 0; i < 4; i++) begin
      chk("hold_in_ready_low", {63'd0, in_ready}, 64'd0);
      chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_stable_a", out_a, a0);
      chk("hold_stable_b", out_b, b0);
      chk("hold_stable_count", {56'd0, out_count}, {56'd0, c0});
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send_beat(64'd77, 1'b1, 1'b0);
    idle(2);

    // 100 then subtract 30.
`ifdef CSA_ACC_SUB_EN
    push(64'd70, 8'd2);
`else
    push(64'd130, 8'd2);
`endif
    send_beat(64'd100, 1'b0, 1'b0);
    send_beat(64'd30, 1'b1, 1'b1);
    idle(2);

    // Count saturates at 255 while the sum keeps going.
    push(64'd300, 8'd255);
    for (int i = 0; i < 300; i++) send_beat(64'd1, (i == 299), 1'b0);
    idle(2);

    // Reset mid-group discards the partial result.
    send_beat(64'd1, 1'b0, 1'b0);
    send_beat(64'd2, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("midreset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midreset_s", out_a, 64'd0);
    chk("midreset_c", out_b, 64'd0);
    chk("midreset_count", {56'd0, out_count}, 64'd0);
    chk("midreset_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    push(64'd8, 8'd2);
    send_beat(64'd4, 1'b0, 1'b0);
    send_beat(64'd4, 1'b1, 1'b0);
    idle(1);

    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
